// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue types and sizing constants.
// FETCH_WIDTH and INST_ADDR_WIDTH come from the global defines; defaults are provided here.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package fetch_queue_pkg;

    localparam int unsigned DECODE_WIDTH = 2;
    localparam int unsigned FQ_DEPTH     = 8;

    typedef struct packed {
        logic [31:0]                 inst;
        logic [`INST_ADDR_WIDTH-1:0] pc;
    } fq_entry_t;

    function automatic int unsigned fq_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between IFU and decode: circular queue of single-instruction entries.
// Optional same-cycle bypass on an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module fetch_queue #(
    parameter int unsigned FETCH_WIDTH  = `FETCH_WIDTH,
    parameter int unsigned DECODE_WIDTH = fetch_queue_pkg::DECODE_WIDTH,
    parameter int unsigned DEPTH        = fetch_queue_pkg::FQ_DEPTH
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      flush,
    input  logic                                      enq_valid,
    input  logic [FETCH_WIDTH*32-1:0]                 enq_inst,
    input  logic [`INST_ADDR_WIDTH-1:0]               enq_pc,
    output logic                                      stall,
    input  logic                                      deq_ready,
    output logic [DECODE_WIDTH-1:0]                   deq_valid,
    output logic [DECODE_WIDTH*32-1:0]                deq_inst,
    output logic [DECODE_WIDTH*`INST_ADDR_WIDTH-1:0]  deq_pc,
    output logic [$clog2(DEPTH):0]                    count
);
    import fetch_queue_pkg::*;

    localparam int unsigned AW    = `INST_ADDR_WIDTH;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned N_BYP = fq_min(FETCH_WIDTH, DECODE_WIDTH);

    fq_entry_t       mem [DEPTH];
    fq_entry_t       bundle [FETCH_WIDTH];
    fq_entry_t       rd_entry;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   free_slots;
    logic [CW-1:0]   n_enq;
    logic [CW-1:0]   n_deq;
    logic [CW-1:0]   count_next;
    logic            enq_fire;
    logic            deq_fire;
    logic            bypass;
    int unsigned     skip;

    always_comb begin
        for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            bundle[i].inst = enq_inst[i*32 +: 32];
            bundle[i].pc   = enq_pc + AW'(4 * i);
        end
    end

    // Admission looks only at registered occupancy, so stall never depends on inputs.
    assign free_slots = CW'(DEPTH) - count;
    assign stall      = free_slots < CW'(FETCH_WIDTH);
    assign enq_fire   = enq_valid && !stall && !flush;
    assign deq_fire   = deq_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = enq_fire && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        skip = 0;
        if (bypass && deq_fire) begin
            skip = N_BYP;
        end
        n_enq = enq_fire ? CW'(FETCH_WIDTH - skip) : '0;
        n_deq = '0;
        if (deq_fire && !bypass) begin
            n_deq = (count < CW'(DECODE_WIDTH)) ? count : CW'(DECODE_WIDTH);
        end
        count_next = count + n_enq - n_deq;
    end

    always_comb begin
        deq_valid = '0;
        deq_inst  = '0;
        deq_pc    = '0;
        rd_entry  = '0;
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
            rd_entry                = mem[head + PW'(i)];
            deq_valid[i]            = (CW'(i) < count) && !flush;
            deq_inst[i*32 +: 32]    = rd_entry.inst;
            deq_pc[i*AW +: AW]      = rd_entry.pc;
        end
        // Bypass overrides the (empty) stored view with the incoming bundle.
        for (int unsigned i = 0; i < N_BYP; i++) begin
            if (bypass) begin
                deq_valid[i]         = 1'b1;
                deq_inst[i*32 +: 32] = bundle[i].inst;
                deq_pc[i*AW +: AW]   = bundle[i].pc;
            end
        end
    end

    // Slots consumed by bypass are skipped; the remainder is packed from tail.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
                if (i >= skip) begin
                    mem[tail + PW'(i - skip)] <= bundle[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_deq);
            tail  <= tail + PW'(n_enq);
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (FETCH_WIDTH=2, DECODE_WIDTH=2, DEPTH=8); follows FETCH_QUEUE_BYPASS_EN.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned AW = `INST_ADDR_WIDTH;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            enq_valid;
    logic [63:0]     enq_inst;
    logic [AW-1:0]   enq_pc;
    logic            stall;
    logic            deq_ready;
    logic [1:0]      deq_valid;
    logic [63:0]     deq_inst;
    logic [2*AW-1:0] deq_pc;
    logic [3:0]      count;

    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;
    fq_entry_t       sb [$];

    fetch_queue #(
        .FETCH_WIDTH  (2),
        .DECODE_WIDTH (2),
        .DEPTH        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_inst  (enq_inst),
        .enq_pc    (enq_pc),
        .stall     (stall),
        .deq_ready (deq_ready),
        .deq_valid (deq_valid),
        .deq_inst  (deq_inst),
        .deq_pc    (deq_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One cycle: drive at posedge+1, compare at negedge against the scoreboard, update model.
    task automatic step(input logic ev, input logic [AW-1:0] pc, input logic dr, input logic fl);
        fq_entry_t   bun [2];
        fq_entry_t   exp_e;
        int unsigned sz;
        logic        exp_stall;
        logic        fire;
        logic        byp;
        logic [1:0]  exp_v;
        for (int i = 0; i < 2; i++) begin
            bun[i].inst = $urandom;
            bun[i].pc   = pc + AW'(4 * i);
            enq_inst[i*32 +: 32] = bun[i].inst;
        end
        enq_valid = ev;
        enq_pc    = pc;
        deq_ready = dr;
        flush     = fl;
        @(negedge clk);
        sz        = sb.size();
        exp_stall = (8 - sz) < 2;
        check("count", 64'(count), 64'(sz));
        check("stall", 64'(stall), 64'(exp_stall));
        fire = ev && !exp_stall && !fl;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = fire && (sz == 0);
`else
        byp = 1'b0;
`endif
        if (fl)           exp_v = 2'b00;
        else if (byp)     exp_v = 2'b11;
        else if (sz >= 2) exp_v = 2'b11;
        else if (sz == 1) exp_v = 2'b01;
        else              exp_v = 2'b00;
        check("deq_valid", 64'(deq_valid), 64'(exp_v));
        for (int i = 0; i < 2; i++) begin
            if (exp_v[i]) begin
                exp_e = byp ? bun[i] : sb[i];
                check($sformatf("deq_pc[%0d]", i), 64'(deq_pc[i*AW +: AW]), 64'(exp_e.pc));
                check($sformatf("deq_inst[%0d]", i), 64'(deq_inst[i*32 +: 32]), 64'(exp_e.inst));
            end
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (dr && !byp) begin
                for (int k = 0; k < 2 && sb.size() > 0; k++) void'(sb.pop_front());
            end
            if (fire && !(byp && dr)) begin
                sb.push_back(bun[0]);
                sb.push_back(bun[1]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_inst  = '0;
        enq_pc    = '0;
        deq_ready = 1'b0;

        // Held in reset
        repeat (2) begin
            @(negedge clk);
            check("rst_stall", 64'(stall), 64'd0);
            check("rst_count", 64'(count), 64'd0);
            check("rst_deq_valid", 64'(deq_valid), 64'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill, then a fifth bundle that must be refused
        for (int b = 0; b < 4; b++) step(1'b1, AW'(8 * b), 1'b0, 1'b0);
        step(1'b1, AW'(32), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // In-order drain
        repeat (4) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Steady traffic across the wrap point
        for (int b = 0; b < 3; b++) step(1'b1, AW'(200 + 8 * b), 1'b0, 1'b0);
        for (int b = 0; b < 10; b++) step(1'b1, AW'(224 + 8 * b), 1'b1, 1'b0);

        // Flush wins over same-cycle enqueue and dequeue
        step(1'b1, AW'(32'h500), 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Empty-queue enqueue with and without decode ready
        step(1'b1, AW'(20), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, AW'(40), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-run at occupancy 6
        for (int b = 0; b < 3; b++) step(1'b1, AW'(300 + 8 * b), 1'b0, 1'b0);
        check("pre_reset_count", 64'(count), 64'd6);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        reset     = 1'b0;
        #2;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_stall", 64'(stall), 64'd0);
        check("async_rst_deq_valid", 64'(deq_valid), 64'd0);
        sb.delete();
        reset = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Random traffic
        for (int c = 0; c < 80; c++) begin
            step($urandom_range(0, 3) != 0, AW'(32'h1000 + 8 * c),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        step(1'b0, '0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
